// File: rtl/first_nios2_system_cpu_oci_dct_packer.sv
// Writer side of the OCI DCT trace path: packs 2-bit branch-outcome codes into a
// 15-slot buffer and hands completed or flushed buffers to a one-entry frame register.
module first_nios2_system_cpu_oci_dct_packer #(
    parameter int ENTRY_W = 2,
    parameter int SLOTS   = 15,
    parameter int CNT_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       trace_en,
    input  logic                       dct_valid,
    input  logic [ENTRY_W-1:0]         dct_code,
    output logic                       dct_ready,
    input  logic                       flush,
    output logic [ENTRY_W*SLOTS-1:0]   dct_buffer,
    output logic [CNT_W-1:0]           dct_count,
    output logic                       frm_valid,
    output logic [ENTRY_W*SLOTS-1:0]   frm_data,
    output logic [CNT_W-1:0]           frm_count,
    input  logic                       frm_ready,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int               BUF_W = ENTRY_W * SLOTS;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(SLOTS);

    typedef enum logic [1:0] {EMPTY, FILL, FULL_WAIT} state_t;

    state_t             state;
    logic               flush_pend;
    logic               live;
    logic               frm_free;
    logic               accept;
    logic               drain_full;
    logic               closing;
    logic [BUF_W-1:0]   acc_buf;
    logic [CNT_W-1:0]   acc_cnt;

    // live keeps dct_ready low until the first edge after reset is released.
    always_comb begin
        frm_free   = ~frm_valid | frm_ready;
        dct_ready  = live & trace_en & ((dct_count != FULL) | frm_free);
        accept     = dct_valid & dct_ready;
        drain_full = (state == FULL_WAIT) & frm_free;
        acc_buf    = accept ? {dct_buffer[BUF_W-ENTRY_W-1:0], dct_code} : dct_buffer;
        acc_cnt    = accept ? dct_count + CNT_W'(1) : dct_count;
        closing    = (acc_cnt == FULL) | ((flush | flush_pend) & (acc_cnt != '0));
    end

    // NOTE: every register here uses <= so all updates see pre-edge values; blocking
    // assignments would let later statements read half-updated state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            live       <= 1'b0;
            flush_pend <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
            frm_valid  <= 1'b0;
            frm_data   <= '0;
            frm_count  <= '0;
            overflow   <= 1'b0;
        end else begin
            live <= 1'b1;

            if (live & dct_valid & trace_en & ~dct_ready)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;

            if (frm_valid & frm_ready)
                frm_valid <= 1'b0;

            if (!trace_en) begin
                state      <= EMPTY;
                flush_pend <= 1'b0;
                dct_buffer <= '0;
                dct_count  <= '0;
            end else if (drain_full) begin
                // Full buffer moves out; a code accepted on this edge starts a fresh buffer.
                frm_valid <= 1'b1;
                frm_data  <= dct_buffer;
                frm_count <= FULL;
                if (accept) begin
                    state      <= FILL;
                    flush_pend <= flush;
                    dct_buffer <= BUF_W'(dct_code);
                    dct_count  <= CNT_W'(1);
                end else begin
                    state      <= EMPTY;
                    flush_pend <= 1'b0;
                    dct_buffer <= '0;
                    dct_count  <= '0;
                end
            end else if (closing & frm_free) begin
                frm_valid  <= 1'b1;
                frm_data   <= acc_buf;
                frm_count  <= acc_cnt;
                state      <= EMPTY;
                flush_pend <= 1'b0;
                dct_buffer <= '0;
                dct_count  <= '0;
            end else begin
                // Frame register busy (or no close): keep packing, remember any flush.
                dct_buffer <= acc_buf;
                dct_count  <= acc_cnt;
                flush_pend <= flush_pend | (flush & (acc_cnt != '0));
                if (acc_cnt == FULL)
                    state <= FULL_WAIT;
                else if (acc_cnt != '0)
                    state <= FILL;
                else
                    state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer: expected frames are queued as stimulus is
// issued and a negedge monitor compares every frame the sink accepts.
module tb_first_nios2_system_cpu_oci_dct_packer;

    typedef struct packed {
        logic [29:0] data;
        logic [3:0]  cnt;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trace_en;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        dct_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [29:0] frm_data;
    logic [3:0]  frm_count;
    logic        frm_ready;
    logic        overflow;
    logic        overflow_clr;

    int     n_cmp = 0;
    int     n_err = 0;
    frame_t exp_q[$];
    frame_t got_e;

    first_nios2_system_cpu_oci_dct_packer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trace_en     (trace_en),
        .dct_valid    (dct_valid),
        .dct_code     (dct_code),
        .dct_ready    (dct_ready),
        .flush        (flush),
        .dct_buffer   (dct_buffer),
        .dct_count    (dct_count),
        .frm_valid    (frm_valid),
        .frm_data     (frm_data),
        .frm_count    (frm_count),
        .frm_ready    (frm_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted frame must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && frm_valid && frm_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: got data %0h count %0d, expected none",
                         frm_data, frm_count);
            end else begin
                got_e = exp_q.pop_front();
                check("frm_data", {2'b00, frm_data}, {2'b00, got_e.data});
                check("frm_count", {28'd0, frm_count}, {28'd0, got_e.cnt});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] code);
        dct_valid = 1'b1;
        dct_code  = code;
        step();
        dct_valid = 1'b0;
    endtask

    task automatic send_n(input logic [1:0] code, input int n);
        dct_valid = 1'b1;
        dct_code  = code;
        repeat (n) step();
        dct_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic push(input logic [29:0] data, input logic [3:0] cnt);
        frame_t f;
        f.data = data;
        f.cnt  = cnt;
        exp_q.push_back(f);
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dct_ready"},  {31'd0, dct_ready}, 0);
        check({tag, "_dct_buffer"}, {2'b00, dct_buffer}, 0);
        check({tag, "_dct_count"},  {28'd0, dct_count}, 0);
        check({tag, "_frm_valid"},  {31'd0, frm_valid}, 0);
        check({tag, "_frm_data"},   {2'b00, frm_data}, 0);
        check({tag, "_frm_count"},  {28'd0, frm_count}, 0);
        check({tag, "_overflow"},   {31'd0, overflow}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        trace_en     = 1'b1;
        dct_valid    = 1'b0;
        dct_code     = 2'b00;
        flush        = 1'b0;
        frm_ready    = 1'b1;
        overflow_clr = 1'b0;
        #12;
        check_all_zero("reset");
        #1 reset_n = 1'b1;
        step();

        // T1: 15 codes of 01 close a full frame.
        push(30'h15555555, 4'hF);
        send_n(2'b01, 15);
        check("t1_frm_valid", {31'd0, frm_valid}, 1);
        check("t1_dct_count", {28'd0, dct_count}, 0);
        step();
        check("t1_overflow", {31'd0, overflow}, 0);

        // T2: three codes then flush.
        push(30'h39, 4'd3);
        send(2'b11);
        send(2'b10);
        send(2'b01);
        do_flush();
        check("t2_dct_buffer", {2'b00, dct_buffer}, 0);
        check("t2_frm_valid", {31'd0, frm_valid}, 1);
        step();

        // T3: flush together with an accepted code includes that code.
        push(30'h2B, 4'd3);
        send(2'b10);
        send(2'b10);
        dct_valid = 1'b1;
        dct_code  = 2'b11;
        flush     = 1'b1;
        step();
        dct_valid = 1'b0;
        flush     = 1'b0;
        check("t3_dct_count", {28'd0, dct_count}, 0);
        step();
        step();

        // T4: backpressure, FULL_WAIT and overflow.
        frm_ready = 1'b0;
        push(30'h2AAAAAAA, 4'hF);
        push(30'h3FFFFFFF, 4'hF);
        send_n(2'b10, 15);
        send_n(2'b11, 15);
        check("t4_dct_ready", {31'd0, dct_ready}, 0);
        check("t4_dct_count", {28'd0, dct_count}, 15);
        send(2'b01);
        check("t4_overflow", {31'd0, overflow}, 1);
        check("t4_dct_buffer", {2'b00, dct_buffer}, 32'h3FFFFFFF);
        frm_ready = 1'b1;
        step();
        check("t4_frm2_valid", {31'd0, frm_valid}, 1);
        check("t4_count_after", {28'd0, dct_count}, 0);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("t4_overflow_clr", {31'd0, overflow}, 0);

        // T5: empty flush, pending flush, and trace disable.
        do_flush();
        step();
        step();
        check("t5_empty_flush", {31'd0, frm_valid}, 0);
        frm_ready = 1'b0;
        push(30'h15, 4'd3);
        send_n(2'b01, 3);
        do_flush();
        push(30'h2D, 4'd3);
        send(2'b10);
        send(2'b11);
        do_flush();
        send(2'b01);
        check("t5_pend_count", {28'd0, dct_count}, 3);
        frm_ready = 1'b1;
        step();
        frm_ready = 1'b0;
        check("t5_pend_loaded", {31'd0, frm_valid}, 1);
        check("t5_pend_cleared", {28'd0, dct_count}, 0);
        send_n(2'b01, 5);
        check("t5_count5", {28'd0, dct_count}, 5);
        check("t5_buf5", {2'b00, dct_buffer}, 32'h155);
        trace_en = 1'b0;
        step();
        check("t5_dis_count", {28'd0, dct_count}, 0);
        check("t5_dis_buffer", {2'b00, dct_buffer}, 0);
        check("t5_dis_frame_kept", {31'd0, frm_valid}, 1);
        trace_en  = 1'b1;
        frm_ready = 1'b1;
        wait_drain();

        // T6: asynchronous reset mid-fill with a frame held.
        frm_ready = 1'b0;
        send_n(2'b01, 2);
        do_flush();
        send_n(2'b10, 7);
        check("t6_count7", {28'd0, dct_count}, 7);
        check("t6_frm_valid", {31'd0, frm_valid}, 1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("t6");
        #15 reset_n = 1'b1;
        step();
        check("t6_ready_after", {31'd0, dct_ready}, 1);
        frm_ready = 1'b1;
        step();
        step();
        check("t6_no_frame", {31'd0, frm_valid}, 0);

        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
